ram_lsu: RTL and testbench



---
 rtl/ram_lsu_pkg.sv | 51 +++++
 rtl/ram_lsu_align.sv | 57 +++++
 rtl/ram_lsu.sv | 191 +++++++++++++++++++
 tb/tb_ram_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_lsu_pkg.sv
// Shared types and helpers for the byte-enabled RAM load/store initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: size encodings, FSM states, byte-mask/size helpers and the
// load-pipeline tag layout.
package ram_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  // Travels alongside each issued read so the returning ram_q can be
  // interpreted one cycle later.
  typedef struct packed {
    logic       vld;     // a read was issued last cycle
    logic [1:0] off;     // byte offset of the original request
    logic [1:0] size;    // request size encoding
    logic       sgn;     // sign-extend on completion
    logic       first;   // first half of a split read
    logic       second;  // second half of a split read
  } tag_t;

  // Size 3 is treated as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_mask = 4'b0001;
      SZ_HALF: byte_mask = 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // True when the access spills past the end of its word.
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
    is_split = ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/ram_lsu_align.sv
// Lane alignment: store shift/mask generation and load merge/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   st_off/st_size/st_second/st_wdata -> st_wren/st_data  (store side)
//   ld_off/ld_size/ld_signed/ld_second/ld_q/ld_lo -> ld_data (load side)
module ram_lsu_align
  import ram_lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic        st_second,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wren,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic        ld_second,
  input  logic [31:0] ld_q,
  input  logic [31:0] ld_lo,
  output logic [31:0] ld_data
);

  logic [7:0]  mask_wide;
  logic [63:0] data_wide;
  logic [63:0] ld_wide;
  logic [31:0] ld_aligned;

  // Shifting into a two-word window yields both halves of a split access at
  // once: the low word is the first RAM access, the high word the second.
  always_comb begin
    mask_wide = {4'b0000, byte_mask(st_size)} << st_off;
    data_wide = {32'h0, st_wdata} << {st_off, 3'b000};
    if (st_second) begin
      st_wren = mask_wide[7:4];
      st_data = data_wide[63:32];
    end else begin
      st_wren = mask_wide[3:0];
      st_data = data_wide[31:0];
    end
  end

  // The low buffer holds the whole first word; selecting 32 bits starting at
  // the byte offset picks lanes off..3 of it followed by the second word.
  always_comb begin
    ld_wide    = ld_second ? {ld_q, ld_lo} : {32'h0, ld_q};
    ld_aligned = ld_wide[{ld_off, 3'b000} +: 32];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_aligned[7]}}, ld_aligned[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & ld_aligned[15]}}, ld_aligned[15:0]};
      default: ld_data = ld_aligned;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store initiator for a byte-enabled simple-dual-port RAM; splits unaligned accesses.
// Latency: aligned load rsp 2 cycles after accept, split load 3 cycles; stores have no rsp.
// Backpressure: req_ready drops for the one cycle a split's second access issues; rsp has none.
//
// Ports:
//   clock, reset_n                      clock and async active-low reset
//   req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata  request
//   rsp_valid, rsp_rdata                extended load data, one-cycle pulse
//   ram_data/ram_wraddress/ram_wren     RAM write port
//   ram_rdaddress/ram_rden/ram_q        RAM read port (q one cycle after address)
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  output logic [3:0]            ram_wren,
  output logic                  ram_rden,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] WA_ONE = ADDR_WIDTH'(1);

  state_t state, state_nxt;

  logic accept;
  logic req_split;

  // Request held for the second half of a split access.
  logic                  l_write;
  logic                  l_signed;
  logic [1:0]            l_size;
  logic [1:0]            l_off;
  logic [ADDR_WIDTH-1:0] l_wa;
  logic [31:0]           l_wdata;

  // The access being presented to the RAM this cycle.
  logic                  iss;
  logic                  i_write;
  logic                  i_signed;
  logic                  i_first;
  logic                  i_second;
  logic [1:0]            i_size;
  logic [1:0]            i_off;
  logic [ADDR_WIDTH-1:0] i_wa;
  logic [31:0]           i_wdata;

  tag_t        s1_tag, tag_nxt;
  logic [31:0] lo_buf;
  logic [3:0]  st_wren;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign req_split = is_split(req_addr[1:0], req_size);
  assign accept    = req_valid && req_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && req_split) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / issue select ----------------
  always_comb begin
    req_ready = 1'b0;
    iss       = 1'b0;
    i_write   = req_write;
    i_signed  = req_signed;
    i_size    = req_size;
    i_off     = req_addr[1:0];
    i_wa      = req_addr[ADDR_WIDTH+1:2];
    i_wdata   = req_wdata;
    i_first   = req_split;
    i_second  = 1'b0;
    case (state)
      IDLE: begin
        // reset_n gating keeps ready low while reset is held.
        req_ready = reset_n;
        iss       = req_valid & reset_n;
      end
      SECOND: begin
        iss      = 1'b1;
        i_write  = l_write;
        i_signed = l_signed;
        i_size   = l_size;
        i_off    = l_off;
        i_wa     = l_wa + WA_ONE;  // wraps to word 0 at the top of the RAM
        i_wdata  = l_wdata;
        i_first  = 1'b0;
        i_second = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- split request latch ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      l_write  <= 1'b0;
      l_signed <= 1'b0;
      l_size   <= 2'd0;
      l_off    <= 2'd0;
      l_wa     <= '0;
      l_wdata  <= 32'h0;
    end else if (state == IDLE && accept && req_split) begin
      l_write  <= req_write;
      l_signed <= req_signed;
      l_size   <= req_size;
      l_off    <= req_addr[1:0];
      l_wa     <= req_addr[ADDR_WIDTH+1:2];
      l_wdata  <= req_wdata;
    end
  end

  // ---------------- lane alignment ----------------
  ram_lsu_align u_align (
    .st_off    (i_off),
    .st_size   (i_size),
    .st_second (i_second),
    .st_wdata  (i_wdata),
    .st_wren   (st_wren),
    .st_data   (st_data),
    .ld_off    (s1_tag.off),
    .ld_size   (s1_tag.size),
    .ld_signed (s1_tag.sgn),
    .ld_second (s1_tag.second),
    .ld_q      (ram_q),
    .ld_lo     (lo_buf),
    .ld_data   (ld_data)
  );

  assign ram_wren      = (iss && i_write) ? st_wren : 4'b0000;
  assign ram_rden      = iss & ~i_write;
  assign ram_wraddress = i_wa;
  assign ram_rdaddress = i_wa;
  assign ram_data      = st_data;

  // ---------------- load pipeline ----------------
  always_comb begin
    tag_nxt        = '0;
    tag_nxt.vld    = iss & ~i_write;
    tag_nxt.off    = i_off;
    tag_nxt.size   = i_size;
    tag_nxt.sgn    = i_signed;
    tag_nxt.first  = i_first;
    tag_nxt.second = i_second;
  end

  // The tag lines up with ram_q one cycle after the read was issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) s1_tag <= '0;
    else          s1_tag <= tag_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lo_buf    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (s1_tag.vld && s1_tag.first) lo_buf <= ram_q;
      rsp_valid <= s1_tag.vld & ~s1_tag.first;
      if (s1_tag.vld && !s1_tag.first) rsp_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
// Latency/backpressure of the DUT are checked via an expected-response queue.
module tb_ram_lsu;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] ram_data;
  logic [7:0]  ram_wraddress;
  logic [7:0]  ram_rdaddress;
  logic [3:0]  ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;

  ram_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .ram_data      (ram_data),
    .ram_wraddress (ram_wraddress),
    .ram_rdaddress (ram_rdaddress),
    .ram_wren      (ram_wren),
    .ram_rden      (ram_rden),
    .ram_q         (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- RAM model: byte-enabled, registered read ----------------
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clock) begin
    for (int k = 0; k < 4; k++)
      if (ram_wren[k]) mem[ram_wraddress][8*k +: 8] = ram_data[8*k +: 8];
    if (ram_rden) ram_q <= mem[ram_rdaddress];
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0] ref_mem [1024];

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q [$];

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [9:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % 1024];
    if (sg && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request; returns at the negedge of the cycle it is accepted in.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                      input logic [31:0] wd, input logic use_exp, input logic [31:0] exp_v);
    int   guard;
    int   n;
    int   off;
    exp_t e;
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    total++;
    assert (req_ready === 1'b1) else begin
      bad++;
      $error("FAIL ready_timeout got=%b exp=1", req_ready);
      req_valid = 1'b0;
      return;
    end
    n   = nbytes(sz);
    off = int'(a[1:0]);
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 1024] = wd[8*i +: 8];
    end else begin
      e.data = use_exp ? exp_v : model_load(a, sz, sg);
      e.cyc  = cyc + ((off + n > 4) ? 3 : 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // ---------------- response checker ----------------
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL rsp_spurious got=%h exp=none", rsp_rdata);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        assert (rsp_rdata === e.data) else begin
          bad++;
          $error("FAIL rsp_data got=%h exp=%h", rsp_rdata, e.data);
        end
        total++;
        assert (cyc === e.cyc) else begin
          bad++;
          $error("FAIL rsp_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      assert (rsp_valid === 1'b1) else begin
        bad++;
        $error("FAIL rsp_missing got=%b exp=1 data=%h", rsp_valid, e.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 10'h0;
    req_wdata  = 32'h0;

    // Reset state
    #3;
    chk("reset_ready", {31'h0, req_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // Preload word 5 and load bytes from it
    send(1'b1, 2'd2, 1'b0, 10'h014, 32'h8899AABB, 1'b0, 32'h0);
    #1 chk("preload_wren", {28'h0, ram_wren}, 32'h0000000F);
    send(1'b0, 2'd0, 1'b1, 10'h016, 32'h0, 1'b1, 32'hFFFFFF99);
    #1 chk("ldb_rden", {31'h0, ram_rden}, 32'h1);
    chk("ldb_rdaddr", {24'h0, ram_rdaddress}, 32'h5);
    chk("ldb_wren", {28'h0, ram_wren}, 32'h0);
    send(1'b0, 2'd0, 1'b0, 10'h016, 32'h0, 1'b1, 32'h00000099);

    // Aligned half store, then word load
    send(1'b1, 2'd1, 1'b0, 10'h00E, 32'h00001234, 1'b0, 32'h0);
    #1 chk("sth_wren", {28'h0, ram_wren}, 32'h0000000C);
    chk("sth_data", ram_data, 32'h12340000);
    chk("sth_wraddr", {24'h0, ram_wraddress}, 32'h3);
    chk("sth_rden", {31'h0, ram_rden}, 32'h0);
    send(1'b0, 2'd2, 1'b0, 10'h00C, 32'h0, 1'b1, 32'h12340000);

    // Split word store at 0x09, then load it back
    send(1'b1, 2'd2, 1'b0, 10'h009, 32'hDEADBEEF, 1'b0, 32'h0);
    #1 chk("stw1_wren", {28'h0, ram_wren}, 32'h0000000E);
    chk("stw1_wraddr", {24'h0, ram_wraddress}, 32'h2);
    chk("stw1_data", ram_data, 32'hADBEEF00);
    idle();
    #1 chk("stw2_ready", {31'h0, req_ready}, 32'h0);
    chk("stw2_wren", {28'h0, ram_wren}, 32'h00000001);
    chk("stw2_wraddr", {24'h0, ram_wraddress}, 32'h3);
    chk("stw2_lane0", {24'h0, ram_data[7:0]}, 32'h000000DE);
    @(negedge clock);
    #1 chk("stw_ready_back", {31'h0, req_ready}, 32'h1);
    send(1'b0, 2'd2, 1'b0, 10'h009, 32'h0, 1'b1, 32'hDEADBEEF);

    // Wrap-around split half load at the top byte address
    send(1'b1, 2'd2, 1'b0, 10'h3FC, 32'h80000000, 1'b0, 32'h0);
    send(1'b1, 2'd2, 1'b0, 10'h000, 32'h0000007F, 1'b0, 32'h0);
    send(1'b0, 2'd1, 1'b1, 10'h3FF, 32'h0, 1'b1, 32'h00007F80);
    #1 chk("wrap1_rdaddr", {24'h0, ram_rdaddress}, 32'h000000FF);
    idle();
    #1 chk("wrap2_rden", {31'h0, ram_rden}, 32'h1);
    chk("wrap2_rdaddr", {24'h0, ram_rdaddress}, 32'h0);

    // Back-to-back aligned loads
    send(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'd2, 1'b0, 10'h004, 32'h0, 1'b0, 32'h0);
    send(1'b0, 2'd2, 1'b0, 10'h008, 32'h0, 1'b0, 32'h0);
    idle();
    repeat (4) @(negedge clock);

    // Reset during the second cycle of a split load
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 10'h011;
    #1 chk("rst_split_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_split_rden1", {31'h0, ram_rden}, 32'h1);
    chk("rst_split_rdaddr1", {24'h0, ram_rdaddress}, 32'h4);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1 chk("rst_split_rden2", {31'h0, ram_rden}, 32'h0);
    chk("rst_split_wren2", {28'h0, ram_wren}, 32'h0);
    chk("rst_split_ready_low", {31'h0, req_ready}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("rst_split_ready_back", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1 chk("rst_split_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end

    // Randomized traffic against the reference memory
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           10'($urandom_range(0, 1023)), $urandom, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
